// File: rtl/reg_read.sv
// Register-read stage: four-lane pipeline register that resolves source operands
// against same-cycle writeback and tracks branch-mask kill/clear on held lanes.
module reg_read #(
    parameter int unsigned WIDTH     = 96,
    parameter int unsigned WIDTH_REG = 5,
    parameter int unsigned WIDTH_BRM = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [3:0]                      i_valid,
    input  logic [WIDTH-1:0]                i_instr0,
    input  logic [WIDTH-1:0]                i_instr1,
    input  logic [WIDTH-1:0]                i_instr2,
    input  logic [WIDTH-1:0]                i_instr3,
    input  logic [WIDTH_BRM-1:0]            i_brmask0,
    input  logic [WIDTH_BRM-1:0]            i_brmask1,
    input  logic [WIDTH_BRM-1:0]            i_brmask2,
    input  logic [WIDTH_BRM-1:0]            i_brmask3,
    output logic                            o_ready,
    output logic [2*WIDTH_REG-1:0]          o_raddr0,
    output logic [2*WIDTH_REG-1:0]          o_raddr1,
    output logic [2*WIDTH_REG-1:0]          o_raddr2,
    output logic [2*WIDTH_REG-1:0]          o_raddr3,
    input  logic [63:0]                     i_rdata0,
    input  logic [63:0]                     i_rdata1,
    input  logic [63:0]                     i_rdata2,
    input  logic [63:0]                     i_rdata3,
    input  logic [3:0]                      i_wb_en,
    input  logic [WIDTH_REG-1:0]            i_wb_addr0,
    input  logic [WIDTH_REG-1:0]            i_wb_addr1,
    input  logic [WIDTH_REG-1:0]            i_wb_addr2,
    input  logic [WIDTH_REG-1:0]            i_wb_addr3,
    input  logic [31:0]                     i_wb_data0,
    input  logic [31:0]                     i_wb_data1,
    input  logic [31:0]                     i_wb_data2,
    input  logic [31:0]                     i_wb_data3,
    input  logic                            i_stall,
    input  logic                            i_flush,
    input  logic [WIDTH_BRM-1:0]            i_kill_mask,
    input  logic [WIDTH_BRM-1:0]            i_clr_mask,
    output logic [3:0]                      o_valid,
    output logic [WIDTH-2*WIDTH_REG-1:0]    o_instr0,
    output logic [WIDTH-2*WIDTH_REG-1:0]    o_instr1,
    output logic [WIDTH-2*WIDTH_REG-1:0]    o_instr2,
    output logic [WIDTH-2*WIDTH_REG-1:0]    o_instr3,
    output logic [63:0]                     o_regFile0,
    output logic [63:0]                     o_regFile1,
    output logic [63:0]                     o_regFile2,
    output logic [63:0]                     o_regFile3,
    output logic [WIDTH_BRM-1:0]            o_brmask0,
    output logic [WIDTH_BRM-1:0]            o_brmask1,
    output logic [WIDTH_BRM-1:0]            o_brmask2,
    output logic [WIDTH_BRM-1:0]            o_brmask3
);

    localparam int unsigned LANES = 4;
    localparam int unsigned RW    = 2 * WIDTH_REG;
    localparam int unsigned IW    = WIDTH - RW;

    logic [WIDTH-1:0]     instr_in [LANES];
    logic [63:0]          rdata_in [LANES];
    logic [WIDTH_BRM-1:0] bm_in    [LANES];
    logic [WIDTH_REG-1:0] wb_addr  [LANES];
    logic [31:0]          wb_data  [LANES];

    logic [LANES-1:0]     valid_q, valid_d;
    logic [IW-1:0]        instr_q  [LANES];
    logic [IW-1:0]        instr_d  [LANES];
    logic [63:0]          rf_q     [LANES];
    logic [63:0]          rf_d     [LANES];
    logic [WIDTH_BRM-1:0] bm_q     [LANES];
    logic [WIDTH_BRM-1:0] bm_d     [LANES];
    logic [WIDTH_REG-1:0] rs1_q    [LANES];
    logic [WIDTH_REG-1:0] rs1_d    [LANES];
    logic [WIDTH_REG-1:0] rs2_q    [LANES];
    logic [WIDTH_REG-1:0] rs2_d    [LANES];
    logic [WIDTH_BRM-1:0] ld_bm    [LANES];
    logic [LANES-1:0]     ld_valid;

    assign instr_in = '{i_instr0, i_instr1, i_instr2, i_instr3};
    assign rdata_in = '{i_rdata0, i_rdata1, i_rdata2, i_rdata3};
    assign bm_in    = '{i_brmask0, i_brmask1, i_brmask2, i_brmask3};
    assign wb_addr  = '{i_wb_addr0, i_wb_addr1, i_wb_addr2, i_wb_addr3};
    assign wb_data  = '{i_wb_data0, i_wb_data1, i_wb_data2, i_wb_data3};

    // Ascending scan so the highest-numbered matching writeback port wins.
    function automatic logic [31:0] wb_pick(input logic [WIDTH_REG-1:0] idx,
                                            input logic [31:0] dflt);
        logic [31:0] r;
        r = dflt;
        for (int p = 0; p < LANES; p++) begin
            if (i_wb_en[p] && (idx != '0) && (wb_addr[p] == idx)) begin
                r = wb_data[p];
            end
        end
        return r;
    endfunction

    // Next-state: capture new lanes or refresh held operands, then kill/clear masks.
    always_comb begin
        valid_d  = '0;
        ld_valid = valid_q;
        for (int n = 0; n < LANES; n++) begin
            instr_d[n] = instr_q[n];
            rs1_d[n]   = rs1_q[n];
            rs2_d[n]   = rs2_q[n];
            ld_bm[n]   = bm_q[n];
            rf_d[n]    = {wb_pick(rs2_q[n], rf_q[n][63:32]), wb_pick(rs1_q[n], rf_q[n][31:0])};
            if (!i_stall) begin
                instr_d[n]  = instr_in[n][WIDTH-1:RW];
                rs1_d[n]    = instr_in[n][WIDTH_REG-1:0];
                rs2_d[n]    = instr_in[n][RW-1:WIDTH_REG];
                ld_bm[n]    = bm_in[n];
                ld_valid[n] = i_valid[n];
                rf_d[n][31:0]  = (rs1_d[n] == '0) ? 32'h0 : wb_pick(rs1_d[n], rdata_in[n][31:0]);
                rf_d[n][63:32] = (rs2_d[n] == '0) ? 32'h0 : wb_pick(rs2_d[n], rdata_in[n][63:32]);
            end
            valid_d[n] = ~i_flush & ld_valid[n] & ~(|(ld_bm[n] & i_kill_mask));
            bm_d[n]    = ld_bm[n] & ~i_clr_mask;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            for (int n = 0; n < LANES; n++) begin
                instr_q[n] <= '0;
                rf_q[n]    <= '0;
                bm_q[n]    <= '0;
                rs1_q[n]   <= '0;
                rs2_q[n]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int n = 0; n < LANES; n++) begin
                instr_q[n] <= instr_d[n];
                rf_q[n]    <= rf_d[n];
                bm_q[n]    <= bm_d[n];
                rs1_q[n]   <= rs1_d[n];
                rs2_q[n]   <= rs2_d[n];
            end
        end
    end

    assign o_ready    = ~i_stall;
    assign o_raddr0   = i_instr0[RW-1:0];
    assign o_raddr1   = i_instr1[RW-1:0];
    assign o_raddr2   = i_instr2[RW-1:0];
    assign o_raddr3   = i_instr3[RW-1:0];
    assign o_valid    = valid_q;
    assign o_instr0   = instr_q[0];
    assign o_instr1   = instr_q[1];
    assign o_instr2   = instr_q[2];
    assign o_instr3   = instr_q[3];
    assign o_regFile0 = rf_q[0];
    assign o_regFile1 = rf_q[1];
    assign o_regFile2 = rf_q[2];
    assign o_regFile3 = rf_q[3];
    assign o_brmask0  = bm_q[0];
    assign o_brmask1  = bm_q[1];
    assign o_brmask2  = bm_q[2];
    assign o_brmask3  = bm_q[3];

endmodule

// File: tb/tb_reg_read.sv
// Bench for reg_read: directed scenarios plus randomized traffic against a lane-level model.
module tb_reg_read;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid;
    logic [95:0] instr   [4];
    logic [3:0]  brmask  [4];
    logic [63:0] rdata   [4];
    logic [3:0]  wb_en;
    logic [4:0]  wb_addr [4];
    logic [31:0] wb_data [4];
    logic        stall, flush;
    logic [3:0]  kill, clr;

    logic        ready;
    logic [9:0]  raddr [4];
    logic [3:0]  ovalid;
    logic [85:0] oinstr [4];
    logic [63:0] orf    [4];
    logic [3:0]  obm    [4];

    int checks = 0;
    int errors = 0;

    // Model state: what each output lane should hold after the last edge.
    logic [3:0]  e_valid;
    logic [85:0] e_instr [4];
    logic [63:0] e_rf    [4];
    logic [3:0]  e_bm    [4];
    logic [4:0]  e_rs1   [4];
    logic [4:0]  e_rs2   [4];

    always #5 clk = ~clk;

    reg_read dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
        .i_instr0(instr[0]), .i_instr1(instr[1]), .i_instr2(instr[2]), .i_instr3(instr[3]),
        .i_brmask0(brmask[0]), .i_brmask1(brmask[1]), .i_brmask2(brmask[2]), .i_brmask3(brmask[3]),
        .o_ready(ready),
        .o_raddr0(raddr[0]), .o_raddr1(raddr[1]), .o_raddr2(raddr[2]), .o_raddr3(raddr[3]),
        .i_rdata0(rdata[0]), .i_rdata1(rdata[1]), .i_rdata2(rdata[2]), .i_rdata3(rdata[3]),
        .i_wb_en(wb_en),
        .i_wb_addr0(wb_addr[0]), .i_wb_addr1(wb_addr[1]), .i_wb_addr2(wb_addr[2]), .i_wb_addr3(wb_addr[3]),
        .i_wb_data0(wb_data[0]), .i_wb_data1(wb_data[1]), .i_wb_data2(wb_data[2]), .i_wb_data3(wb_data[3]),
        .i_stall(stall), .i_flush(flush), .i_kill_mask(kill), .i_clr_mask(clr),
        .o_valid(ovalid),
        .o_instr0(oinstr[0]), .o_instr1(oinstr[1]), .o_instr2(oinstr[2]), .o_instr3(oinstr[3]),
        .o_regFile0(orf[0]), .o_regFile1(orf[1]), .o_regFile2(orf[2]), .o_regFile3(orf[3]),
        .o_brmask0(obm[0]), .o_brmask1(obm[1]), .o_brmask2(obm[2]), .o_brmask3(obm[3])
    );

    // Operand source: x0 reads zero, otherwise the highest enabled writeback port naming it.
    function automatic logic [31:0] m_src(input logic [4:0] idx, input logic [31:0] fallback);
        if (idx == 5'd0) return 32'h0;
        for (int p = 3; p >= 0; p--)
            if (wb_en[p] && wb_addr[p] == idx) return wb_data[p];
        return fallback;
    endfunction

    task automatic model_reset();
        e_valid = 4'h0;
        for (int n = 0; n < 4; n++) begin
            e_instr[n] = '0; e_rf[n] = '0; e_bm[n] = '0; e_rs1[n] = '0; e_rs2[n] = '0;
        end
    endtask

    task automatic model_step();
        logic [3:0] bm;
        logic       v;
        for (int n = 0; n < 4; n++) begin
            if (!stall) begin
                bm         = brmask[n];
                v          = valid[n];
                e_rs1[n]   = instr[n][4:0];
                e_rs2[n]   = instr[n][9:5];
                e_instr[n] = instr[n][95:10];
                e_rf[n]    = {m_src(e_rs2[n], rdata[n][63:32]), m_src(e_rs1[n], rdata[n][31:0])};
            end else begin
                bm      = e_bm[n];
                v       = e_valid[n];
                e_rf[n] = {m_src(e_rs2[n], e_rf[n][63:32]), m_src(e_rs1[n], e_rf[n][31:0])};
            end
            e_valid[n] = !flush && v && ((bm & kill) == 4'h0);
            e_bm[n]    = bm & ~clr;
        end
    endtask

    task automatic idle_inputs();
        valid = 4'h0; wb_en = 4'h0; stall = 1'b0; flush = 1'b0; kill = 4'h0; clr = 4'h0;
        for (int n = 0; n < 4; n++) begin
            instr[n] = '0; brmask[n] = '0; rdata[n] = '0; wb_addr[n] = '0; wb_data[n] = '0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (oinstr[n] !== 86'h0 || orf[n] !== 64'h0 || obm[n] !== 4'h0) begin
                errors++;
                $display("FAIL reset_lane%0d: instr=%h rf=%h bm=%h required all zero", n, oinstr[n], orf[n], obm[n]);
            end
        end
        checks++;
        if (ovalid !== 4'h0) begin
            errors++;
            $display("FAIL reset_valid: got %h required 0", ovalid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_operand();
        idle_inputs();
        valid    = 4'b0001;
        instr[0] = {86'h2BAD, 5'd0, 5'd3};
        rdata[0] = {32'h5, 32'hAAAA};
        #1;
        checks++;
        if (raddr[0] !== 10'h003 || ready !== 1'b1) begin
            errors++;
            $display("FAIL raddr_ready: raddr0=%h ready=%b required 003/1", raddr[0], ready);
        end
        tick();
        checks++;
        if (orf[0] !== {32'h0, 32'hAAAA} || ovalid[0] !== 1'b1 || oinstr[0] !== 86'h2BAD) begin
            errors++;
            $display("FAIL operand_x0: rf0=%h v0=%b instr0=%h required 00000000_0000aaaa/1/2bad", orf[0], ovalid[0], oinstr[0]);
        end
    endtask

    task automatic test_wb_priority();
        idle_inputs();
        valid    = 4'b0001;
        instr[0] = {86'h1, 5'd4, 5'd3};
        rdata[0] = {32'h4444, 32'h3333};
        wb_en    = 4'b0101;
        wb_addr[0] = 5'd3; wb_data[0] = 32'h11;
        wb_addr[2] = 5'd3; wb_data[2] = 32'h22;
        wb_addr[3] = 5'd3; wb_data[3] = 32'h33;
        tick();
        checks++;
        if (orf[0] !== {32'h4444, 32'h22}) begin
            errors++;
            $display("FAIL wb_priority: rf0=%h required 00004444_00000022", orf[0]);
        end
    endtask

    task automatic test_stall_wb();
        idle_inputs();
        valid    = 4'b0010;
        instr[1] = {86'h3C0FFEE, 5'd7, 5'd1};
        rdata[1] = {32'h1234, 32'h5678};
        tick();
        checks++;
        if (orf[1] !== {32'h1234, 32'h5678} || oinstr[1] !== 86'h3C0FFEE) begin
            errors++;
            $display("FAIL stall_capture: rf1=%h instr1=%h required 00001234_00005678/3c0ffee", orf[1], oinstr[1]);
        end
        stall    = 1'b1;
        instr[1] = {86'h999, 5'd2, 5'd2};
        rdata[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_stall: got %b required 0", ready);
        end
        tick();
        wb_en = 4'b0010; wb_addr[1] = 5'd7; wb_data[1] = 32'h77;
        tick();
        checks++;
        if (orf[1] !== {32'h77, 32'h5678} || oinstr[1] !== 86'h3C0FFEE || ovalid[1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_wb: rf1=%h instr1=%h v1=%b required 00000077_00005678/3c0ffee/1", orf[1], oinstr[1], ovalid[1]);
        end
    endtask

    task automatic test_kill_clear();
        idle_inputs();
        valid = 4'hF;
        brmask[0] = 4'b0001; brmask[1] = 4'b1000; brmask[2] = 4'b0110; brmask[3] = 4'b0100;
        tick();
        stall = 1'b1;
        kill  = 4'b0010;
        clr   = 4'b0100;
        tick();
        checks++;
        if (ovalid !== 4'b1011 || obm[3] !== 4'h0 || obm[2] !== 4'b0010) begin
            errors++;
            $display("FAIL kill_clear: valid=%b bm3=%b bm2=%b required 1011/0000/0010", ovalid, obm[3], obm[2]);
        end
        kill = 4'b0001;
        clr  = 4'b0001;
        tick();
        checks++;
        if (ovalid !== 4'b1010 || obm[0] !== 4'h0) begin
            errors++;
            $display("FAIL kill_wins: valid=%b bm0=%b required 1010/0000", ovalid, obm[0]);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        valid = 4'hF;
        flush = 1'b1;
        tick();
        checks++;
        if (ovalid !== 4'h0) begin
            errors++;
            $display("FAIL flush: valid=%b required 0000", ovalid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            valid = 4'($urandom);
            stall = ($urandom_range(0, 9) < 4);
            flush = ($urandom_range(0, 19) == 0);
            kill  = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            clr   = 4'($urandom) & 4'($urandom);
            wb_en = 4'($urandom);
            for (int n = 0; n < 4; n++) begin
                instr[n]   = {$urandom, $urandom, $urandom};
                instr[n][4:0] = 5'($urandom_range(0, 7));
                instr[n][9:5] = 5'($urandom_range(0, 7));
                brmask[n]  = 4'($urandom);
                rdata[n]   = {$urandom, $urandom};
                wb_addr[n] = 5'($urandom_range(0, 7));
                wb_data[n] = $urandom;
            end
            #1;
            checks++;
            if (raddr[0] !== instr[0][9:0] || raddr[3] !== instr[3][9:0] || ready !== !stall) begin
                errors++;
                $display("FAIL rand_comb c%0d: raddr0=%h raddr3=%h ready=%b", c, raddr[0], raddr[3], ready);
            end
            tick();
            checks++;
            if (ovalid !== e_valid) begin
                errors++;
                $display("FAIL rand_valid c%0d: got %b required %b", c, ovalid, e_valid);
            end
            for (int n = 0; n < 4; n++) begin
                checks++;
                if (oinstr[n] !== e_instr[n] || orf[n] !== e_rf[n] || obm[n] !== e_bm[n]) begin
                    errors++;
                    $display("FAIL rand_lane%0d c%0d: instr=%h/%h rf=%h/%h bm=%b/%b (got/required)",
                             n, c, oinstr[n], e_instr[n], orf[n], e_rf[n], obm[n], e_bm[n]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        valid = 4'hF;
        rdata[0] = 64'h1;
        instr[0] = {86'h0, 5'd0, 5'd9};
        tick();
        stall = 1'b1;
        tick();
        checks++;
        if (ovalid !== 4'hF) begin
            errors++;
            $display("FAIL pre_reset_hold: valid=%b required 1111", ovalid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ovalid !== 4'h0 || orf[0] !== 64'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%b rf0=%h required 0/0", ovalid, orf[0]);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        idle_inputs();
        valid = 4'b0001;
        tick();
        checks++;
        if (ovalid !== 4'b0001) begin
            errors++;
            $display("FAIL first_capture: valid=%b required 0001", ovalid);
        end
    endtask

    initial begin
        test_reset();
        test_operand();
        test_wb_priority();
        test_stall_wb();
        test_kill_clear();
        test_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
